// File: rtl/quadenc_game_pkg.sv
// Shared encodings and defaults for the position-targeting game sequencer.
// Pure definitions; no timing or flow control of its own.
package quadenc_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } game_state_t;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    localparam int HOLD_CYC_DEF = 8;
    localparam int TIME_CYC_DEF = 1024;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/quadenc_lfsr.sv
// Free-running 8-bit maximal LFSR, exposes its low OUT_W bits.
// Advances every cycle out of reset; no stall input.
module quadenc_lfsr
    import quadenc_game_pkg::*;
#(
    parameter logic [7:0] SEED  = LFSR_SEED_DEF,
    parameter int         OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd
);

    logic [7:0] state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

    assign rnd = state[OUT_W-1:0];

endmodule

// File: rtl/quadenc_game_ctrl.sv
// Encoder game: saturating position, random target, dwell-to-win with a round timeout.
// Registered outputs, decisions act on last cycle's pos/target; step pulses are never stalled.
module quadenc_game_ctrl
    import quadenc_game_pkg::*;
#(
    parameter int         POS_W     = 4,
    parameter int         HOLD_CYC  = HOLD_CYC_DEF,
    parameter int         TIME_CYC  = TIME_CYC_DEF,
    parameter int         SCORE_W   = 8,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               cw_in,
    input  logic               acw_in,
    output logic [POS_W-1:0]   pos_out,
    output logic [POS_W-1:0]   target_out,
    output logic [1:0]         state_out,
    output logic [SCORE_W-1:0] score_out,
    output logic               win_out,
    output logic               timeout_out,
    output logic               busy_out
);

    localparam int TIMER_W = $clog2(TIME_CYC);
    localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};

    game_state_t        state;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   pos_nxt;
    logic [POS_W-1:0]   target;
    logic [POS_W-1:0]   rnd;
    logic [TIMER_W-1:0] timer;
    logic [HOLD_W-1:0]  hold;
    logic [SCORE_W-1:0] score;
    logic               on_target;
    logic               win_now;
    logic               time_up;

    quadenc_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (POS_W)
    ) u_lfsr (
        .clk (clk_in),
        .rst (rst_in),
        .rnd (rnd)
    );

    always_comb begin
        pos_nxt = pos;
        if (cw_in && !acw_in && pos != POS_MAX) begin
            pos_nxt = pos + 1'b1;
        end else if (acw_in && !cw_in && pos != '0) begin
            pos_nxt = pos - 1'b1;
        end
    end

    assign on_target = (pos == target);
    assign win_now   = (state == ST_HOLD) && on_target && (hold == HOLD_W'(HOLD_CYC - 1));
    assign time_up   = (timer == TIMER_W'(TIME_CYC - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            pos         <= '0;
            target      <= '0;
            timer       <= '0;
            hold        <= '0;
            score       <= '0;
            win_out     <= 1'b0;
            timeout_out <= 1'b0;
            busy_out    <= 1'b0;
        end else begin
            win_out     <= 1'b0;
            timeout_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        state    <= ST_PLAY;
                        timer    <= '0;
                        hold     <= '0;
                        busy_out <= 1'b1;
                        // Nudge the target off the current position so a round never starts already won
                        target   <= (rnd == pos) ? (rnd ^ POS_W'(1)) : rnd;
                    end
                end
                ST_PLAY, ST_HOLD: begin
                    pos   <= pos_nxt;
                    timer <= timer + 1'b1;
                    if (win_now) begin
                        state    <= ST_DONE;
                        win_out  <= 1'b1;
                        busy_out <= 1'b0;
                        if (score != {SCORE_W{1'b1}}) begin
                            score <= score + 1'b1;
                        end
                    end else if (time_up) begin
                        state       <= ST_DONE;
                        timeout_out <= 1'b1;
                        busy_out    <= 1'b0;
                    end else if (state == ST_PLAY) begin
                        if (on_target) begin
                            state <= ST_HOLD;
                            hold  <= '0;
                        end
                    end else if (on_target) begin
                        hold <= hold + 1'b1;
                    end else begin
                        state <= ST_PLAY;
                        hold  <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pos_out    = pos;
    assign target_out = target;
    assign state_out  = state;
    assign score_out  = score;

endmodule
